julia_iter_engine: RTL and testbench
====================================

// Module: julia_iter_engine
// PURPOSE
//  Iterative escape-time engine: z <= z^2 + c from a seed, one iteration per clock, until
//  |z|^2 > 4 or MAX_ITER iterations. Replaces the single-step Julia calculator; sits between
//  the pixel coordinate generator and the colour mapper. Valid/ready on both sides.
// PARAMETERS
//  WIDTH     32  signed fixed-point width of x, y, cr, ci, out_wx, out_wy
//  FRAC      16  fractional bits (1.0 = 2**FRAC)
//  MAX_ITER  64  iteration limit, >= 1
//  ITER_W    8   width of out_iter; must hold MAX_ITER
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  in_valid     in   1      seed/constant valid
//  in_ready     out  1      engine idle, seed accepted when in_valid & in_ready
//  in_x, in_y   in   WIDTH  seed z0 (signed)
//  cr, ci       in   WIDTH  constant c (signed), sampled at accept
//  out_valid    out  1      result valid
//  out_ready    in   1      result consumed when out_valid & out_ready
//  out_iter     out  ITER_W iterations completed
//  out_escaped  out  1      1 = |z|^2 > 4 reached, 0 = hit MAX_ITER
//  out_wx,out_wy out WIDTH  final z
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, out_iter=0, out_escaped=0, out_wx=out_wy=0.
//  Reset mid-ITER/DONE: job dropped, no output, IDLE next cycle.
//  FSM IDLE -> ITER -> DONE -> IDLE; in_ready = (state==IDLE), out_valid = (state==DONE).
//  IDLE: on accept latch z=(in_x,in_y), c=(cr,ci), iter=0 -> ITER. in_valid otherwise ignored.
//  ITER, each cycle on current z:
//   xx=(x*x)>>>FRAC, yy=(y*y)>>>FRAC, xy2=(2*x*y)>>>FRAC; products 2*WIDTH signed,
//   arithmetic shift (floor toward -inf).
//   mag = xx+yy at 2*WIDTH+1 bits; escape iff mag > (4 << FRAC), strict.
//   escape: out_iter=iter, out_escaped=1, out_wx/wy=z -> DONE.
//   else z <= (xx-yy+cr, xy2+ci) truncated to WIDTH (two's-complement wrap), iter+1;
//   if iter+1==MAX_ITER: out_iter=MAX_ITER, out_escaped=0, out_wx/wy=new z -> DONE.
//  Latency (accept at edge T): escape at iteration k -> out_valid from T+k+2;
//   non-escape -> out_valid from T+MAX_ITER+1.
//  DONE: outputs held stable while out_ready=0; on out_ready -> IDLE, in_ready=1 next cycle.
//   No same-cycle accept on output handshake (1 bubble per pixel).
//  out_* hold last result after leaving DONE until overwritten.
// CONFIGURATION
//  JL_MANDEL_MODE_EN defined: extra input port `mode` (1 bit, sampled at accept);
//   mode=1 -> z0=(0,0), c=(in_x,in_y), cr/ci ignored; mode=0 -> Julia as above.
//  Not defined: no `mode` port, Julia behaviour only; no other difference.
// TESTING (WIDTH=32, FRAC=16, MAX_ITER=64, 1.0=65536)
//  1 z0=(0,0), c=(0,0) -> out_valid at T+65, out_iter=64, out_escaped=0, wx=wy=0.
//  2 z0=(196608,0), c=0 -> out_valid at T+2, out_iter=0, out_escaped=1, wx=196608.
//  3 z0=(98304,0), c=0 -> z1=(147456,0), out_iter=1, out_escaped=1, out_wx=147456.
//  4 Case 3 with out_ready=0 for 10 cycles -> outputs stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
//  5 Case 1 with rst=1 at T+5 -> out_valid never asserts, in_ready=1 after reset edge; new job runs normally.
//  6 JL_MANDEL_MODE_EN, mode=1, in=(-131072,0) -> z=(-2,0),(2,0),(2,0)..., mag=4 not >4:
//    out_iter=64, out_escaped=0, out_wx=131072.

Source files
------------

// File: rtl/julia_iter_engine.sv
// Escape-time iteration engine: z <= z^2 + c per clock until |z|^2 > 4 or MAX_ITER steps.
// Optional build macro JL_MANDEL_MODE_EN adds a `mode` input (1 = Mandelbrot seeding).
module julia_iter_engine #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int MAX_ITER = 64,
    parameter int ITER_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_y,
    input  logic [WIDTH-1:0]  cr,
    input  logic [WIDTH-1:0]  ci,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
    output logic [WIDTH-1:0]  out_wx,
    output logic [WIDTH-1:0]  out_wy
`ifdef JL_MANDEL_MODE_EN
    ,
    input  logic              mode
`endif
);

    localparam int PW = 2 * WIDTH;
    localparam int MW = 2 * WIDTH + 1;
    localparam logic signed [MW-1:0] THRESH = MW'(4) <<< FRAC;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t state_q, state_d;

    logic signed [WIDTH-1:0] zx_q, zy_q, cr_q, ci_q;
    logic [ITER_W-1:0]       iter_q;
    logic [ITER_W-1:0]       out_iter_q;
    logic                    out_escaped_q;
    logic [WIDTH-1:0]        out_wx_q, out_wy_q;

    logic signed [PW-1:0] pxx, pyy, pxy;
    logic signed [MW-1:0] xx, yy, xy2, mag, nx, ny;
    logic                 escape;
    logic [ITER_W-1:0]    iterNext;
    logic                 lastIter;

    // Squares and cross term are floored (arithmetic shift) in a width that cannot overflow.
    always_comb begin
        pxx      = zx_q * zx_q;
        pyy      = zy_q * zy_q;
        pxy      = zx_q * zy_q;
        xx       = $signed({pxx[PW-1], pxx}) >>> FRAC;
        yy       = $signed({pyy[PW-1], pyy}) >>> FRAC;
        xy2      = $signed({pxy, 1'b0}) >>> FRAC;
        mag      = xx + yy;
        escape   = (mag > THRESH);
        nx       = xx - yy + {{(MW-WIDTH){cr_q[WIDTH-1]}}, cr_q};
        ny       = xy2 + {{(MW-WIDTH){ci_q[WIDTH-1]}}, ci_q};
        iterNext = iter_q + 1'b1;
        lastIter = (iterNext == ITER_W'(MAX_ITER));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)            state_d = ITER;
            ITER:    if (escape || lastIter)  state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zx_q          <= '0;
            zy_q          <= '0;
            cr_q          <= '0;
            ci_q          <= '0;
            iter_q        <= '0;
            out_iter_q    <= '0;
            out_escaped_q <= 1'b0;
            out_wx_q      <= '0;
            out_wy_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        iter_q <= '0;
`ifdef JL_MANDEL_MODE_EN
                        if (mode) begin
                            zx_q <= '0;
                            zy_q <= '0;
                            cr_q <= in_x;
                            ci_q <= in_y;
                        end else begin
                            zx_q <= in_x;
                            zy_q <= in_y;
                            cr_q <= cr;
                            ci_q <= ci;
                        end
`else
                        zx_q <= in_x;
                        zy_q <= in_y;
                        cr_q <= cr;
                        ci_q <= ci;
`endif
                    end
                end
                ITER: begin
                    if (escape) begin
                        out_iter_q    <= iter_q;
                        out_escaped_q <= 1'b1;
                        out_wx_q      <= zx_q;
                        out_wy_q      <= zy_q;
                    end else begin
                        // New z wraps to WIDTH bits; it is also the reported z when the limit is hit.
                        zx_q   <= WIDTH'(nx);
                        zy_q   <= WIDTH'(ny);
                        iter_q <= iterNext;
                        if (lastIter) begin
                            out_iter_q    <= ITER_W'(MAX_ITER);
                            out_escaped_q <= 1'b0;
                            out_wx_q      <= WIDTH'(nx);
                            out_wy_q      <= WIDTH'(ny);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_iter    = out_iter_q;
    assign out_escaped = out_escaped_q;
    assign out_wx      = out_wx_q;
    assign out_wy      = out_wy_q;

endmodule

// File: tb/tb_julia_iter_engine.sv
// Scoreboard bench for julia_iter_engine: directed seeds push expected results,
// a monitor pops and compares whenever out_valid is presented.
module tb_julia_iter_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x, in_y, cr, ci;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_iter;
    logic        out_escaped;
    logic [31:0] out_wx, out_wy;
`ifdef JL_MANDEL_MODE_EN
    logic        mode;
`endif

    int testsRun  = 0;
    int failures  = 0;
    int edgeCount = 0;

    typedef struct {
        logic [7:0]  iter;
        logic        esc;
        logic [31:0] wx;
        logic [31:0] wy;
        int          lat;
        int          stall;
        int          acceptEdge;
    } exp_t;

    exp_t expQ[$];

    julia_iter_engine dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .cr         (cr),
        .ci         (ci),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_iter   (out_iter),
        .out_escaped(out_escaped),
        .out_wx     (out_wx),
        .out_wy     (out_wy)
`ifdef JL_MANDEL_MODE_EN
        ,
        .mode       (mode)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        testsRun++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Waits for the engine to be idle, presents one seed and records what must come back.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] c_r, input logic [31:0] c_i,
                                 input logic [7:0] eIter, input logic eEsc,
                                 input logic [31:0] eWx, input logic [31:0] eWy,
                                 input int lat, input int stall);
        exp_t e;
        int   waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while (!in_ready && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_x     = x;
        in_y     = y;
        cr       = c_r;
        ci       = c_i;
        in_valid = 1'b1;
        e.iter       = eIter;
        e.esc        = eEsc;
        e.wx         = eWx;
        e.wy         = eWy;
        e.lat        = lat;
        e.stall      = stall;
        e.acceptEdge = edgeCount + 1;
        expQ.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: compares each presented result against the scoreboard head.
    initial begin : monitor
        exp_t e;
        bit   holding;
        bit   afterRelease;
        int   stallLeft;
        holding      = 0;
        afterRelease = 0;
        stallLeft    = 0;
        out_ready    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding      = 0;
                afterRelease = 0;
                out_ready    = 1'b0;
            end else if (afterRelease) begin
                out_ready    = 1'b0;
                afterRelease = 0;
                checkOutput("in_ready_after_handshake", 64'(in_ready), 64'd1);
                checkOutput("out_valid_after_handshake", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                if (!holding) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
                        out_ready    = 1'b1;
                        afterRelease = 1;
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("latency", 64'(edgeCount + 1 - e.acceptEdge), 64'(e.lat));
                        checkOutput("out_iter", 64'(out_iter), 64'(e.iter));
                        checkOutput("out_escaped", 64'(out_escaped), 64'(e.esc));
                        checkOutput("out_wx", {32'd0, out_wx}, {32'd0, e.wx});
                        checkOutput("out_wy", {32'd0, out_wy}, {32'd0, e.wy});
                        holding   = 1;
                        stallLeft = e.stall;
                    end
                end else begin
                    checkOutput("hold_out_iter", 64'(out_iter), 64'(e.iter));
                    checkOutput("hold_out_wx", {32'd0, out_wx}, {32'd0, e.wx});
                    checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
                end
                if (holding) begin
                    if (stallLeft == 0) begin
                        out_ready    = 1'b1;
                        holding      = 0;
                        afterRelease = 1;
                    end else begin
                        stallLeft--;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int T;
        int guard;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        cr       = '0;
        ci       = '0;
`ifdef JL_MANDEL_MODE_EN
        mode     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_iter", 64'(out_iter), 64'd0);
        checkOutput("reset_out_escaped", 64'(out_escaped), 64'd0);
        checkOutput("reset_out_wx", {32'd0, out_wx}, 64'd0);
        checkOutput("reset_out_wy", {32'd0, out_wy}, 64'd0);
        rst = 1'b0;

        //            x        y      cr       ci   iter esc wx        wy   lat stall
        applyStimulus(0,       0,     0,       0,   64, 0, 0,        0,   65, 0);
        applyStimulus(196608,  0,     0,       0,   0,  1, 196608,   0,   2,  0);
        applyStimulus(98304,   0,     0,       0,   1,  1, 147456,   0,   3,  0);
        applyStimulus(98304,   0,     0,       0,   1,  1, 147456,   0,   3,  10);
        applyStimulus(131072,  0,     0,       0,   1,  1, 262144,   0,   3,  0);
        applyStimulus(0,       0,     -131072, 0,   64, 0, 131072,   0,   65, 0);
        applyStimulus(65536,   65536, 0,       0,   2,  1, -262144,  0,   4,  0);
        applyStimulus(-1,      1,     196608,  0,   1,  1, 196608,   -1,  3,  0);
        applyStimulus(0,       98304, 0,       0,   1,  1, -147456,  0,   3,  0);

        // Reset while a job is iterating: the job must vanish without a result.
        guard = 0;
        @(negedge clk);
        while ((!in_ready || expQ.size() != 0) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        in_x     = '0;
        in_y     = '0;
        cr       = '0;
        ci       = '0;
        in_valid = 1'b1;
        T        = edgeCount + 1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("busy_in_ready", 64'(in_ready), 64'd0);
        while (edgeCount < T + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_out_iter", 64'(out_iter), 64'd0);
        checkOutput("midreset_out_wx", {32'd0, out_wx}, 64'd0);
        repeat (80) @(negedge clk);

        applyStimulus(98304,   0,     0,       0,   1,  1, 147456,   0,   3,  0);

`ifdef JL_MANDEL_MODE_EN
        mode = 1'b1;
        applyStimulus(-131072, 0,     12345,   777, 64, 0, 131072,   0,   65, 0);
        mode = 1'b0;
`endif

        guard = 0;
        while ((expQ.size() != 0 || out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
